// File: rtl/sort_pkg.sv
// Shared types and constants for the sort sequencer and its compare-exchange unit.
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sort_state_t;

  localparam int unsigned SORT_N = 8;
  localparam int unsigned SORT_W = 32;

  // Compare-exchange cycles for a full odd-even transposition sort of n elements.
  function automatic int unsigned total_cycles(input int unsigned n);
    return (n / 2) * (n / 2) + (n / 2) * (n / 2 - 1);
  endfunction

endpackage

// File: rtl/sort_sequencer_if.sv
// CSR-facing bundle of the sort sequencer: start strobe, input array and result/status readback.
interface sort_sequencer_if
  import sort_pkg::*;
#(
  parameter int unsigned N = SORT_N,
  parameter int unsigned W = SORT_W
) ();

  logic           start_i;
  logic [N*W-1:0] data_i;
  logic [N*W-1:0] data_o;
  logic           busy_o;
  logic           result_valid_o;
  logic           start_err_o;
  logic [15:0]    swap_cnt_o;

  // CSR block side
  modport master (
    output start_i, data_i,
    input  data_o, busy_o, result_valid_o, start_err_o, swap_cnt_o
  );

  // Sequencer side
  modport slave (
    input  start_i, data_i,
    output data_o, busy_o, result_valid_o, start_err_o, swap_cnt_o
  );

endinterface

// File: rtl/sort_cmp_swap.sv
// Combinational compare-exchange: orders one pair, flags whether it was out of order.
module sort_cmp_swap #(
  parameter int unsigned W      = 32,
  parameter bit          SIGNED = 1'b1
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] lo_o,
  output logic [W-1:0] hi_o,
  output logic         swapped_o
);

  logic w_gt;

  // Strict greater-than so equal elements stay in place.
  assign w_gt      = SIGNED ? ($signed(a_i) > $signed(b_i)) : (a_i > b_i);
  assign lo_o      = w_gt ? b_i : a_i;
  assign hi_o      = w_gt ? a_i : b_i;
  assign swapped_o = w_gt;

endmodule

// File: rtl/sort_sequencer.sv
// Odd-even transposition sort sequencer: latches the array on start, runs one
// compare-exchange per cycle through N passes, then publishes the result.
module sort_sequencer
  import sort_pkg::*;
#(
  parameter int unsigned N      = SORT_N,
  parameter int unsigned W      = SORT_W,
  parameter bit          SIGNED = 1'b1
) (
  input logic             clk_i,
  input logic             rst_ni,
  sort_sequencer_if.slave bus
);

  localparam int unsigned PW = $clog2(N);
  localparam int unsigned IW = (N > 2) ? $clog2(N / 2) : 1;

  sort_state_t    r_state, w_state_next;
  logic [W-1:0]   r_work [N];
  logic [PW-1:0]  r_pass;
  logic [IW-1:0]  r_idx;
  logic [15:0]    r_swap_cnt;
  logic [N*W-1:0] r_data_o;
  logic [15:0]    r_swap_cnt_o;
  logic           r_valid;
  logic           r_start_err;

  logic           w_latch, w_step, w_publish, w_start_err, w_busy;
  logic           w_last_pair, w_last_pass, w_sort_end;
  logic [IW:0]    w_lo_idx, w_hi_idx;
  logic [W-1:0]   w_lo, w_hi;
  logic           w_swapped;

  // Even passes start at element 0, odd passes at element 1.
  assign w_lo_idx    = {r_idx, 1'b0} + {{IW{1'b0}}, r_pass[0]};
  assign w_hi_idx    = w_lo_idx + {{IW{1'b0}}, 1'b1};
  assign w_last_pair = r_pass[0] ? (r_idx == IW'(N / 2 - 2)) : (r_idx == IW'(N / 2 - 1));
  // With N=2 the odd pass is empty, so the single even pass finishes the sort.
  assign w_last_pass = (N == 2) || (r_pass == PW'(N - 1));
  assign w_sort_end  = w_last_pair && w_last_pass;

  sort_cmp_swap #(
    .W      (W),
    .SIGNED (SIGNED)
  ) u_cmp (
    .a_i       (r_work[w_lo_idx]),
    .b_i       (r_work[w_hi_idx]),
    .lo_o      (w_lo),
    .hi_o      (w_hi),
    .swapped_o (w_swapped)
  );

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.start_i) w_state_next = RUN;
      RUN:     if (w_sort_end) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    w_latch     = 1'b0;
    w_step      = 1'b0;
    w_publish   = 1'b0;
    w_busy      = 1'b1;
    w_start_err = bus.start_i;
    unique case (r_state)
      IDLE: begin
        w_latch     = bus.start_i;
        w_busy      = 1'b0;
        w_start_err = 1'b0;
      end
      RUN:     w_step    = 1'b1;
      DONE:    w_publish = 1'b1;
      default: ;
    endcase
  end

  // Work array, pass/pair counters and swap counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < N; k++) r_work[k] <= '0;
      r_pass     <= '0;
      r_idx      <= '0;
      r_swap_cnt <= '0;
    end else if (w_latch) begin
      for (int unsigned k = 0; k < N; k++) r_work[k] <= bus.data_i[k*W +: W];
      r_pass     <= '0;
      r_idx      <= '0;
      r_swap_cnt <= '0;
    end else if (w_step) begin
      r_work[w_lo_idx] <= w_lo;
      r_work[w_hi_idx] <= w_hi;
      if (w_swapped && (r_swap_cnt != 16'hFFFF)) r_swap_cnt <= r_swap_cnt + 16'd1;
      if (w_last_pair) begin
        r_idx  <= '0;
        r_pass <= r_pass + PW'(1);
      end else begin
        r_idx  <= r_idx + IW'(1);
      end
    end
  end

  // Published result, valid flag and start-error pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data_o     <= '0;
      r_swap_cnt_o <= '0;
      r_valid      <= 1'b0;
      r_start_err  <= 1'b0;
    end else begin
      r_start_err <= w_start_err;
      if (w_latch) r_valid <= 1'b0;
      if (w_publish) begin
        for (int unsigned k = 0; k < N; k++) r_data_o[k*W +: W] <= r_work[k];
        r_swap_cnt_o <= r_swap_cnt;
        r_valid      <= 1'b1;
      end
    end
  end

  assign bus.data_o         = r_data_o;
  assign bus.busy_o         = w_busy;
  assign bus.result_valid_o = r_valid;
  assign bus.start_err_o    = r_start_err;
  assign bus.swap_cnt_o     = r_swap_cnt_o;

endmodule

// File: tb/tb_sort_sequencer.sv
// Scoreboard bench for sort_sequencer: one signed and one unsigned instance on a shared clock.
module tb_sort_sequencer;
  import sort_pkg::*;

  localparam int unsigned N   = SORT_N;
  localparam int unsigned W   = SORT_W;
  localparam int unsigned LAT = total_cycles(N) + 2;

  typedef struct packed {
    logic [N*W-1:0] data;
    logic [15:0]    swaps;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  bit             cur_u;
  logic           tb_start;
  logic [N*W-1:0] tb_data;
  logic [N*W-1:0] m_data;
  logic           m_busy, m_valid, m_err;
  logic [15:0]    m_swaps;
  exp_t           sb_q[$];
  int             n_checks = 0;
  int             n_errors = 0;

  always #5 clk = ~clk;

  sort_sequencer_if #(.N(N), .W(W)) bus_s ();
  sort_sequencer_if #(.N(N), .W(W)) bus_u ();

  sort_sequencer #(.N(N), .W(W), .SIGNED(1'b1)) u_dut_s (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_s)
  );

  sort_sequencer #(.N(N), .W(W), .SIGNED(1'b0)) u_dut_u (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_u)
  );

  assign bus_s.start_i = tb_start & ~cur_u;
  assign bus_u.start_i = tb_start & cur_u;
  assign bus_s.data_i  = tb_data;
  assign bus_u.data_i  = tb_data;

  always_comb begin
    if (cur_u) begin
      m_data  = bus_u.data_o;
      m_busy  = bus_u.busy_o;
      m_valid = bus_u.result_valid_o;
      m_err   = bus_u.start_err_o;
      m_swaps = bus_u.swap_cnt_o;
    end else begin
      m_data  = bus_s.data_o;
      m_busy  = bus_s.busy_o;
      m_valid = bus_s.result_valid_o;
      m_err   = bus_s.start_err_o;
      m_swaps = bus_s.swap_cnt_o;
    end
  end

  task automatic check_eq(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pk(input int e0, input int e1, input int e2, input int e3,
                                        input int e4, input int e5, input int e6, input int e7);
    logic [N*W-1:0] v;
    v[0*W +: W] = e0; v[1*W +: W] = e1; v[2*W +: W] = e2; v[3*W +: W] = e3;
    v[4*W +: W] = e4; v[5*W +: W] = e5; v[6*W +: W] = e6; v[7*W +: W] = e7;
    return v;
  endfunction

  function automatic bit model_gt(input logic [W-1:0] a, input logic [W-1:0] b, input bit uns);
    if (uns) return a > b;
    return $signed(a) > $signed(b);
  endfunction

  // Reference sort: plain insertion sort.
  function automatic logic [N*W-1:0] model_sort(input logic [N*W-1:0] v, input bit uns);
    logic [W-1:0]   e [N];
    logic [W-1:0]   t;
    logic [N*W-1:0] r;
    for (int i = 0; i < int'(N); i++) e[i] = v[i*W +: W];
    for (int i = 1; i < int'(N); i++) begin
      for (int j = i; j > 0; j--) begin
        if (!model_gt(e[j-1], e[j], uns)) break;
        t = e[j]; e[j] = e[j-1]; e[j-1] = t;
      end
    end
    for (int i = 0; i < int'(N); i++) r[i*W +: W] = e[i];
    return r;
  endfunction

  // Each adjacent exchange removes exactly one inversion.
  function automatic int inv_count(input logic [N*W-1:0] v, input bit uns);
    int n = 0;
    for (int i = 0; i < int'(N); i++)
      for (int j = i + 1; j < int'(N); j++)
        if (model_gt(v[i*W +: W], v[j*W +: W], uns)) n++;
    return n;
  endfunction

  function automatic logic [N*W-1:0] rand_vec();
    logic [N*W-1:0] v;
    for (int k = 0; k < int'(N); k++) v[k*W +: W] = int'($urandom_range(0, 40)) - 20;
    return v;
  endfunction

  task automatic do_sort(input bit uns, input bit b2b, input logic [N*W-1:0] vin,
                         input logic [N*W-1:0] exp_data, input int exp_swaps,
                         input int err_at, input string tag);
    logic [N*W-1:0] prev;
    int             busy_cnt = 0;
    int             err_cnt  = 0;
    int             lat      = 0;
    bit             hold_bad = 1'b0;
    exp_t           e;
    if (!b2b) @(negedge clk);
    cur_u   = uns;
    tb_data = vin;
    #1;
    prev     = m_data;
    tb_start = 1'b1;
    sb_q.push_back('{data: exp_data, swaps: 16'(exp_swaps)});
    for (int c = 1; c <= int'(LAT) + 20; c++) begin
      @(negedge clk);
      tb_start = 1'b0;
      if (c == err_at) begin
        tb_start = 1'b1;
        tb_data  = ~vin;
      end
      if (m_busy) busy_cnt++;
      if (m_err) err_cnt++;
      if (c == 1) begin
        check_eq({tag, ":busy_rise"}, m_busy, 1'b1);
        check_eq({tag, ":valid_drop"}, m_valid, 1'b0);
      end
      if (m_valid) begin
        lat = c;
        break;
      end
      if (m_data !== prev) hold_bad = 1'b1;
    end
    tb_start = 1'b0;
    check_eq({tag, ":latency"}, lat, LAT);
    check_eq({tag, ":busy_cycles"}, busy_cnt, LAT - 1);
    check_eq({tag, ":busy_fall"}, m_busy, 1'b0);
    check_eq({tag, ":start_err"}, err_cnt, (err_at > 0) ? 1 : 0);
    check_eq({tag, ":data_hold"}, hold_bad, 1'b0);
    e = sb_q.pop_front();
    check_eq({tag, ":data"}, m_data, e.data);
    check_eq({tag, ":swaps"}, m_swaps, e.swaps);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N*W-1:0] v;
    rst_n    = 1'b0;
    cur_u    = 1'b0;
    tb_start = 1'b0;
    tb_data  = '0;
    repeat (2) @(negedge clk);
    check_eq("rst:data", bus_s.data_o, '0);
    check_eq("rst:busy", bus_s.busy_o, 1'b0);
    check_eq("rst:valid", bus_s.result_valid_o, 1'b0);
    check_eq("rst:err", bus_s.start_err_o, 1'b0);
    check_eq("rst:swaps", bus_s.swap_cnt_o, '0);
    rst_n = 1'b1;

    v = pk(0, -111, 234, 100, 363455, 2525, -1, 6);
    do_sort(1'b0, 1'b0, v, pk(-111, -1, 0, 6, 100, 234, 2525, 363455), inv_count(v, 1'b0), 0,
            "signed1");
    v = pk(120, 2111, -234, -100, 0, -2525, 0, 6);
    do_sort(1'b0, 1'b0, v, pk(-2525, -234, -100, 0, 0, 6, 120, 2111), inv_count(v, 1'b0), 0,
            "dups");
    v = pk(-1, 5, 0, 0, 0, 0, 0, 0);
    do_sort(1'b1, 1'b0, v, pk(0, 0, 0, 0, 0, 0, 5, -1), inv_count(v, 1'b1), 0, "unsigned");
    do_sort(1'b1, 1'b0, pk(7, 6, 5, 4, 3, 2, 1, 0), pk(0, 1, 2, 3, 4, 5, 6, 7), 28, 0, "reversed");
    v = pk(5, -3, 9, 9, -8, 0, 2, 1);
    do_sort(1'b0, 1'b0, v, model_sort(v, 1'b0), inv_count(v, 1'b0), 10, "busy_start");
    v = pk(1, 2, 3, 4, 5, 6, 7, 8);
    do_sort(1'b0, 1'b1, v, v, 0, 0, "sorted_b2b");

    // Reset in the middle of a sort.
    @(negedge clk);
    cur_u   = 1'b0;
    tb_data = pk(9, 8, 7, 6, 5, 4, 3, 2);
    #1 tb_start = 1'b1;
    @(negedge clk);
    tb_start = 1'b0;
    repeat (14) @(negedge clk);
    check_eq("midrst:busy_before", bus_s.busy_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst:data", bus_s.data_o, '0);
    check_eq("midrst:busy", bus_s.busy_o, 1'b0);
    check_eq("midrst:valid", bus_s.result_valid_o, 1'b0);
    check_eq("midrst:err", bus_s.start_err_o, 1'b0);
    check_eq("midrst:swaps", bus_s.swap_cnt_o, '0);
    check_eq("midrst:data_u", bus_u.data_o, '0);
    @(negedge clk);
    rst_n = 1'b1;
    v = pk(3, -4, 3, 0, 12, -7, 1, 1);
    do_sort(1'b0, 1'b0, v, model_sort(v, 1'b0), inv_count(v, 1'b0), 0, "after_rst");

    for (int r = 0; r < 4; r++) begin
      bit uns;
      uns = r[0];
      v = rand_vec();
      do_sort(uns, 1'b0, v, model_sort(v, uns), inv_count(v, uns), 0, "random");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
